// File: rtl/save_pkg.sv
// save_pkg: shared types and constants for the to_save controller.
// Imported by the arbiter and the scheduler top.
package save_pkg;

    localparam int CODE_W = 8;
    localparam logic [1:0] ID_BCAST = 2'd3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETUP   = 2'd1,
        STROBE  = 2'd2,
        RELEASE = 2'd3
    } state_t;

    // Round-robin step: (p + k) mod 3 for p in 0..2, k in 0..2.
    function automatic logic [1:0] rr_add(input logic [1:0] p, input int k);
        logic [2:0] s;
        s = {1'b0, p} + 3'(k);
        return (s >= 3'd3) ? 2'(s - 3'd3) : s[1:0];
    endfunction

endpackage

// File: rtl/save_rr_arb.sv
// save_rr_arb: 3-way round-robin arbiter, purely combinational.
// Scans req upward from ptr, wrapping 2->0.
module save_rr_arb
    import save_pkg::*;
(
    input  logic [2:0] req,
    input  logic [1:0] ptr,
    output logic [2:0] gnt,
    output logic [1:0] idx,
    output logic       any
);

    logic [1:0] cand;

    // Walk candidates from farthest to nearest so the nearest wins.
    always_comb begin
        gnt  = 3'b000;
        idx  = 2'd0;
        cand = 2'd0;
        for (int k = 2; k >= 0; k--) begin
            cand = rr_add(ptr, k);
            if (cand != 2'd3 && req[cand]) begin
                gnt = 3'b001 << cand;
                idx = cand;
            end
        end
        any = |req;
    end

endmodule

// File: rtl/save_sched.sv
// save_sched: arbitrates requesters onto the to_save datapath,
// sequences inp/ESC strobes and returns YP/YC to the winner.
module save_sched
    import save_pkg::*;
#(
    parameter int HOLD_CYCLES  = 4,
    parameter int SETUP_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [2:0]        req,
    input  logic [CODE_W-1:0] code0,
    input  logic [CODE_W-1:0] code1,
    input  logic [CODE_W-1:0] code2,
    input  logic              bcast_req,
    input  logic [CODE_W-1:0] bcast_code,
    output logic [2:0]        ack,
    output logic              bcast_ack,
    output logic              res_valid,
    output logic [1:0]        res_id,
    output logic              res_yp,
    output logic              res_yc,
    output logic              busy,
    output logic [CODE_W-1:0] inp,
    output logic              ESC1,
    output logic              ESC2,
    output logic              ESC3,
    input  logic              YP,
    input  logic              YC
);

    localparam logic [3:0] SETUP_LAST = 4'(SETUP_CYCLES - 1);
    localparam logic [3:0] HOLD_LAST  = 4'(HOLD_CYCLES - 1);

    state_t      state;
    logic [3:0]  cnt;
    logic [1:0]  id;
    logic [1:0]  rr_ptr;
    logic [2:0]  esc;
    logic [2:0]  arb_gnt;
    logic [1:0]  arb_idx;
    logic        arb_any;
    logic [2:0]  esc_mask;
    logic [CODE_W-1:0] sel_code;

    save_rr_arb u_arb (
        .req (req),
        .ptr (rr_ptr),
        .gnt (arb_gnt),
        .idx (arb_idx),
        .any (arb_any)
    );

    assign ESC1 = esc[0];
    assign ESC2 = esc[1];
    assign ESC3 = esc[2];

    // Strobe group for the current owner and code of the arbiter winner.
    always_comb begin
        esc_mask = (id == ID_BCAST) ? 3'b111 : (3'b001 << id);
        sel_code = code0;
        unique case (1'b1)
            arb_gnt[1]: sel_code = code1;
            arb_gnt[2]: sel_code = code2;
            default:    sel_code = code0;
        endcase
    end

    // Transaction FSM; every output is a register updated here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            id        <= 2'd0;
            rr_ptr    <= 2'd0;
            esc       <= 3'b000;
            inp       <= '0;
            ack       <= 3'b000;
            bcast_ack <= 1'b0;
            res_valid <= 1'b0;
            res_id    <= 2'd0;
            res_yp    <= 1'b0;
            res_yc    <= 1'b0;
            busy      <= 1'b0;
        end else begin
            ack       <= 3'b000;
            bcast_ack <= 1'b0;
            res_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    // No grant in the ack cycle: the winner is still
                    // dropping its request.
                    if (!res_valid) begin
                        if (bcast_req) begin
                            id    <= ID_BCAST;
                            inp   <= bcast_code;
                            cnt   <= 4'd0;
                            busy  <= 1'b1;
                            state <= SETUP;
                        end else if (arb_any) begin
                            id    <= arb_idx;
                            inp   <= sel_code;
                            cnt   <= 4'd0;
                            busy  <= 1'b1;
                            state <= SETUP;
                        end
                    end
                end
                SETUP: begin
                    if (cnt == SETUP_LAST) begin
                        cnt   <= 4'd0;
                        esc   <= esc_mask;
                        state <= STROBE;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                STROBE: begin
                    if (cnt == HOLD_LAST) begin
                        cnt    <= 4'd0;
                        esc    <= 3'b000;
                        res_yp <= YP;
                        res_yc <= YC;
                        state  <= RELEASE;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                RELEASE: begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    res_valid <= 1'b1;
                    res_id    <= id;
                    if (id == ID_BCAST) begin
                        bcast_ack <= 1'b1;
                    end else begin
                        ack    <= 3'b001 << id;
                        rr_ptr <= (id == 2'd2) ? 2'd0 : id + 2'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
